// File: rtl/decode_stage.sv
// ID stage: instruction decode, register file with WB bypass,
// early beq/j resolution and the ID/EX pipeline register.
module decode_stage #(
   parameter int NREGS = 32,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [31:0]   InstrD,
   input  logic [DW-1:0] PCPlus4D,
   input  logic          RegWriteW,
   input  logic [4:0]    WriteRegW,
   input  logic [DW-1:0] ResultW,
   input  logic [DW-1:0] ALUOutM,
   input  logic          ForwardAD,
   input  logic          ForwardBD,
   input  logic          FlushE,
   output logic          PCSrcD,
   output logic [DW-1:0] PCBranchD,
   output logic [4:0]    RsD,
   output logic [4:0]    RtD,
   output logic          RegWriteE,
   output logic          MemtoRegE,
   output logic          MemWriteE,
   output logic          ALUSrcE,
   output logic          RegDstE,
   output logic [2:0]    ALUControlE,
   output logic [DW-1:0] RD1E,
   output logic [DW-1:0] RD2E,
   output logic [DW-1:0] SignImmE,
   output logic [4:0]    RsE,
   output logic [4:0]    RtE,
   output logic [4:0]    RdE
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_write;
      logic       alu_src;
      logic       reg_dst;
      logic       branch;
      logic       jump;
      logic [2:0] alu_ctrl;
   } ctl_t;

   typedef struct packed {
      logic          reg_write;
      logic          mem_to_reg;
      logic          mem_write;
      logic          alu_src;
      logic          reg_dst;
      logic [2:0]    alu_ctrl;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic [DW-1:0] sign_imm;
      logic [4:0]    rs;
      logic [4:0]    rt;
      logic [4:0]    rd;
   } id_ex_t;

   logic [5:0]    op;
   logic [5:0]    funct;
   logic [4:0]    rs;
   logic [4:0]    rt;
   logic [4:0]    rd;
   ctl_t          ctl;
   logic [DW-1:0] rf [NREGS];
   logic [DW-1:0] rd1;
   logic [DW-1:0] rd2;
   logic [DW-1:0] sign_imm;
   logic [DW-1:0] cmp_a;
   logic [DW-1:0] cmp_b;
   logic [DW-1:0] br_target;
   logic [DW-1:0] j_target;
   id_ex_t        ex_d;
   id_ex_t        ex_q;

   assign op    = InstrD[31:26];
   assign funct = InstrD[5:0];
   assign rs    = InstrD[25:21];
   assign rt    = InstrD[20:16];
   assign rd    = InstrD[15:11];
   assign RsD   = rs;
   assign RtD   = rt;

   // Unknown opcodes/functs fall through to all-zero control
   always_comb begin
      ctl = '0;
      unique case (op)
         OP_R: begin
            ctl.reg_write = 1'b1;
            ctl.reg_dst   = 1'b1;
            unique case (funct)
               6'b100000: ctl.alu_ctrl = ALU_ADD;
               6'b100010: ctl.alu_ctrl = ALU_SUB;
               6'b100100: ctl.alu_ctrl = ALU_AND;
               6'b100101: ctl.alu_ctrl = ALU_OR;
               6'b101010: ctl.alu_ctrl = ALU_SLT;
               default:   ctl = '0;
            endcase
         end
         OP_LW: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = 1'b1;
            ctl.alu_src    = 1'b1;
            ctl.alu_ctrl   = ALU_ADD;
         end
         OP_SW: begin
            ctl.mem_write = 1'b1;
            ctl.alu_src   = 1'b1;
            ctl.alu_ctrl  = ALU_ADD;
         end
         OP_ADDI: begin
            ctl.reg_write = 1'b1;
            ctl.alu_src   = 1'b1;
            ctl.alu_ctrl  = ALU_ADD;
         end
         OP_BEQ: begin
            ctl.branch   = 1'b1;
            ctl.alu_ctrl = ALU_SUB;
         end
         OP_J:    ctl.jump = 1'b1;
         default: ctl = '0;
      endcase
   end

   // Write-through bypass lets WB feed ID in the same cycle
   always_comb begin
      rd1 = rf[rs];
      rd2 = rf[rt];
      if (RegWriteW && WriteRegW != 5'd0 && WriteRegW == rs)
         rd1 = ResultW;
      if (RegWriteW && WriteRegW != 5'd0 && WriteRegW == rt)
         rd2 = ResultW;
      if (rs == 5'd0)
         rd1 = '0;
      if (rt == 5'd0)
         rd2 = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            rf[i] <= '0;
      end else if (RegWriteW && WriteRegW != 5'd0) begin
         rf[WriteRegW] <= ResultW;
      end
   end

   assign sign_imm  = {{(DW-16){InstrD[15]}}, InstrD[15:0]};
   assign cmp_a     = ForwardAD ? ALUOutM : rd1;
   assign cmp_b     = ForwardBD ? ALUOutM : rd2;
   assign br_target = PCPlus4D + sign_imm;
   assign j_target  = {PCPlus4D[DW-1:26], InstrD[25:0]};
   assign PCSrcD    = rst_n &
                      ((ctl.branch & (cmp_a == cmp_b)) | ctl.jump);
   assign PCBranchD = ctl.jump ? j_target : br_target;

   always_comb begin
      ex_d            = '0;
      ex_d.reg_write  = ctl.reg_write;
      ex_d.mem_to_reg = ctl.mem_to_reg;
      ex_d.mem_write  = ctl.mem_write;
      ex_d.alu_src    = ctl.alu_src;
      ex_d.reg_dst    = ctl.reg_dst;
      ex_d.alu_ctrl   = ctl.alu_ctrl;
      ex_d.rd1        = rd1;
      ex_d.rd2        = rd2;
      ex_d.sign_imm   = sign_imm;
      ex_d.rs         = rs;
      ex_d.rt         = rt;
      ex_d.rd         = rd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ex_q <= '0;
      else if (FlushE)
         ex_q <= '0;
      else
         ex_q <= ex_d;
   end

   assign RegWriteE   = ex_q.reg_write;
   assign MemtoRegE   = ex_q.mem_to_reg;
   assign MemWriteE   = ex_q.mem_write;
   assign ALUSrcE     = ex_q.alu_src;
   assign RegDstE     = ex_q.reg_dst;
   assign ALUControlE = ex_q.alu_ctrl;
   assign RD1E        = ex_q.rd1;
   assign RD2E        = ex_q.rd2;
   assign SignImmE    = ex_q.sign_imm;
   assign RsE         = ex_q.rs;
   assign RtE         = ex_q.rt;
   assign RdE         = ex_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] InstrD;
   logic [31:0] PCPlus4D;
   logic        RegWriteW;
   logic [4:0]  WriteRegW;
   logic [31:0] ResultW;
   logic [31:0] ALUOutM;
   logic        ForwardAD;
   logic        ForwardBD;
   logic        FlushE;
   logic        PCSrcD;
   logic [31:0] PCBranchD;
   logic [4:0]  RsD;
   logic [4:0]  RtD;
   logic        RegWriteE;
   logic        MemtoRegE;
   logic        MemWriteE;
   logic        ALUSrcE;
   logic        RegDstE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E;
   logic [31:0] RD2E;
   logic [31:0] SignImmE;
   logic [4:0]  RsE;
   logic [4:0]  RtE;
   logic [4:0]  RdE;
   logic [4:0]  ctl_e;

   int n_chk  = 0;
   int n_pass = 0;

   decode_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .InstrD     (InstrD),
      .PCPlus4D   (PCPlus4D),
      .RegWriteW  (RegWriteW),
      .WriteRegW  (WriteRegW),
      .ResultW    (ResultW),
      .ALUOutM    (ALUOutM),
      .ForwardAD  (ForwardAD),
      .ForwardBD  (ForwardBD),
      .FlushE     (FlushE),
      .PCSrcD     (PCSrcD),
      .PCBranchD  (PCBranchD),
      .RsD        (RsD),
      .RtD        (RtD),
      .RegWriteE  (RegWriteE),
      .MemtoRegE  (MemtoRegE),
      .MemWriteE  (MemWriteE),
      .ALUSrcE    (ALUSrcE),
      .RegDstE    (RegDstE),
      .ALUControlE(ALUControlE),
      .RD1E       (RD1E),
      .RD2E       (RD2E),
      .SignImmE   (SignImmE),
      .RsE        (RsE),
      .RtE        (RtE),
      .RdE        (RdE)
   );

   always #5 clk = ~clk;

   // {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst}
   assign ctl_e = {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE};

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_e(input string tag,
                        input logic [4:0] ctl,
                        input logic [2:0] alu);
      chk({tag, ".ctl"}, 32'(ctl_e), 32'(ctl));
      chk({tag, ".alu"}, 32'(ALUControlE), 32'(alu));
   endtask

   initial begin
      rst_n     = 1'b0;
      InstrD    = 32'h1000_0005;
      PCPlus4D  = 32'h0000_0100;
      RegWriteW = 1'b0;
      WriteRegW = 5'd0;
      ResultW   = 32'h0;
      ALUOutM   = 32'h0;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      FlushE    = 1'b0;

      // reset with beq $0,$0,+5 present
      tick();
      tick();
      chk("rst.pcsrc", 32'(PCSrcD), 32'h0);
      chk_e("rst", 5'b00000, 3'b000);
      chk("rst.rd1", RD1E, 32'h0);
      chk("rst.imm", SignImmE, 32'h0);
      rst_n = 1'b1;
      #1;
      chk("rel.pcsrc", 32'(PCSrcD), 32'h1);
      chk("rel.target", PCBranchD, 32'h0000_0105);
      tick();
      chk_e("rel.beq", 5'b00000, 3'b110);
      chk("rel.imm", SignImmE, 32'h5);

      // WB bypass: add $9,$8,$8 while $8 is written
      RegWriteW = 1'b1;
      WriteRegW = 5'd8;
      ResultW   = 32'h1234;
      InstrD    = 32'h0108_4820;
      #1;
      chk("byp.rsd", 32'(RsD), 32'd8);
      chk("byp.rtd", 32'(RtD), 32'd8);
      tick();
      chk("byp.rd1", RD1E, 32'h1234);
      chk("byp.rd2", RD2E, 32'h1234);
      chk_e("byp", 5'b10001, 3'b010);
      chk("byp.rde", 32'(RdE), 32'd9);
      chk("byp.rse", 32'(RsE), 32'd8);
      chk("byp.imm", SignImmE, 32'h0000_4820);

      // and $3,$8,$0 reads the stored value
      RegWriteW = 1'b0;
      InstrD    = 32'h0100_1824;
      tick();
      chk("and.rd1", RD1E, 32'h1234);
      chk("and.rd2", RD2E, 32'h0);
      chk_e("and", 5'b10001, 3'b000);

      // register 0 write is ignored
      RegWriteW = 1'b1;
      WriteRegW = 5'd0;
      ResultW   = 32'hFFFF;
      InstrD    = 32'h0000_0825;
      tick();
      chk("r0.byp", RD1E, 32'h0);
      chk_e("r0.or", 5'b10001, 3'b001);
      RegWriteW = 1'b0;
      tick();
      chk("r0.rd1", RD1E, 32'h0);

      // load $1=5, $2=7 with bubbles in decode
      RegWriteW = 1'b1;
      WriteRegW = 5'd1;
      ResultW   = 32'd5;
      InstrD    = 32'h0;
      tick();
      WriteRegW = 5'd2;
      ResultW   = 32'd7;
      tick();
      RegWriteW = 1'b0;
      chk_e("bubble", 5'b00000, 3'b000);
      #1;
      chk("bubble.pcsrc", 32'(PCSrcD), 32'h0);

      // beq $1,$2,-3 with forwarding
      InstrD    = 32'h1022_FFFD;
      PCPlus4D  = 32'h0000_0010;
      ALUOutM   = 32'd7;
      ForwardAD = 1'b1;
      #1;
      chk("fwda.pcsrc", 32'(PCSrcD), 32'h1);
      chk("fwda.target", PCBranchD, 32'h0000_000D);
      ForwardAD = 1'b0;
      #1;
      chk("nofwd.pcsrc", 32'(PCSrcD), 32'h0);
      chk("nofwd.target", PCBranchD, 32'h0000_000D);
      ForwardBD = 1'b1;
      ALUOutM   = 32'd5;
      #1;
      chk("fwdb.pcsrc", 32'(PCSrcD), 32'h1);
      ForwardBD = 1'b0;
      ForwardAD = 1'b1;
      ALUOutM   = 32'd7;
      tick();
      chk("fwd.rd1e", RD1E, 32'd5);
      chk("fwd.rd2e", RD2E, 32'd7);
      chk("fwd.imm", SignImmE, 32'hFFFF_FFFD);
      chk_e("fwd.beq", 5'b00000, 3'b110);
      ForwardAD = 1'b0;

      // jump keeps PC[31:26]
      PCPlus4D = 32'hFC00_0004;
      InstrD   = 32'h0800_0010;
      #1;
      chk("j.pcsrc", 32'(PCSrcD), 32'h1);
      chk("j.target", PCBranchD, 32'hFC00_0010);
      tick();
      chk_e("j", 5'b00000, 3'b000);

      // flush lw $3,4($2) while WB writes $5
      InstrD    = 32'h8C43_0004;
      FlushE    = 1'b1;
      RegWriteW = 1'b1;
      WriteRegW = 5'd5;
      ResultW   = 32'hABCD;
      tick();
      chk_e("flush", 5'b00000, 3'b000);
      chk("flush.rd1", RD1E, 32'h0);
      chk("flush.imm", SignImmE, 32'h0);
      chk("flush.rte", 32'(RtE), 32'd0);
      FlushE    = 1'b0;
      RegWriteW = 1'b0;

      // lw $3,4($5): write during flush landed
      InstrD = 32'h8CA3_0004;
      tick();
      chk_e("lw", 5'b11010, 3'b010);
      chk("lw.rd1", RD1E, 32'hABCD);
      chk("lw.imm", SignImmE, 32'h4);
      chk("lw.rte", 32'(RtE), 32'd3);

      // sw $2,8($1)
      InstrD = 32'hAC22_0008;
      tick();
      chk_e("sw", 5'b00110, 3'b010);
      chk("sw.rd2", RD2E, 32'd7);

      // addi $1,$0,-1
      InstrD = 32'h2001_FFFF;
      tick();
      chk_e("addi", 5'b10010, 3'b010);
      chk("addi.imm", SignImmE, 32'hFFFF_FFFF);

      // illegal opcode 111111
      InstrD = 32'hFC00_0000;
      #1;
      chk("ill.pcsrc", 32'(PCSrcD), 32'h0);
      tick();
      chk_e("ill", 5'b00000, 3'b000);

      // sub $3,$2,$1 and slt $3,$2,$1, then unknown funct
      InstrD = 32'h0041_1822;
      tick();
      chk_e("sub", 5'b10001, 3'b110);
      InstrD = 32'h0041_182A;
      tick();
      chk_e("slt", 5'b10001, 3'b111);
      InstrD = 32'h0041_1821;
      tick();
      chk_e("badfn", 5'b00000, 3'b000);

      // asynchronous reset mid-stream clears registers
      InstrD = 32'h0108_4820;
      tick();
      chk("pre.rd1", RD1E, 32'h1234);
      rst_n = 1'b0;
      #1;
      chk("arst.rd1", RD1E, 32'h0);
      chk_e("arst", 5'b00000, 3'b000);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post.rd1", RD1E, 32'h0);
      chk_e("post", 5'b10001, 3'b010);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
